y86_fetch_sequencer: RTL and testbench
======================================

Name: y86_fetch_sequencer

Overview:
Sequences instruction fetch for the Y86-64 core over a shared byte-wide instruction-memory port. It issues one byte read per request and decodes instruction length from icode on the first byte. It assembles icode/ifun/rA/rB/valC/valP and hands each complete instruction to decode over a valid/ready handshake. Sits between the PC logic and the 2048-byte instruction memory, and replaces the combinational 10-byte window read.

Parameters:
ADDR_W, 64, PC/address width
MAX_ADDR, 2047, highest legal instruction-memory byte address

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pc_load  in  1  redirect pulse; start fetching at pc_in
pc_in  in  ADDR_W  redirect target
mem_req  out  1  byte read request, held until mem_ack
mem_addr  out  ADDR_W  byte address, stable while mem_req=1
mem_ack  in  1  mem_rdata valid this cycle; completes request
mem_rdata  in  8  returned byte
instr_valid  out  1  assembled instruction available
instr_ready  in  1  decode accepts instruction
icode  out  4  byte0[7:4]
ifun  out  4  byte0[3:0]
rA  out  4  byte1[7:4]; 4'hF if no register byte
rB  out  4  byte1[3:0]; 4'hF if no register byte
valC  out  64  little-endian constant; 0 if none
valP  out  ADDR_W  PC + instruction length
instr_error  out  1  with instr_valid: address out of range or invalid icode
halted  out  1  HALTED state

Behaviour:
- Reset: state IDLE, pc=0. All outputs 0 except rA=rB=4'hF. No fetch until first pc_load.
- Length by icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9 (valC = bytes 1..8); 3,4,5 -> 10 (reg byte 1, valC = bytes 2..9). icode > 4'hB -> invalid, length 1.
- States: IDLE, FETCH, DELIVER, HALTED, ERROR, DRAIN.
- IDLE: on pc_load, pc<=pc_in, byte count<=0, go to FETCH.
- FETCH: if pc+count > MAX_ADDR, do not request. Go to DELIVER with instr_error=1 and valP=pc. Otherwise assert mem_req with mem_addr=pc+count. On mem_ack, store the byte at index count and increment count. When count reaches the length (after byte0 when length=1), go to DELIVER on the next cycle.
  - At most one outstanding request. mem_req drops the cycle after ack. Requests are back-to-back otherwise, so minimum latency is N ack cycles + 1.
- DELIVER: instr_valid=1, and fields are held stable until instr_valid&instr_ready.
  - On accept: icode 0 -> HALTED; instr_error -> ERROR; else pc<=valP, count<=0, go to FETCH.
- HALTED / ERROR: outputs idle, halted=1 in HALTED only. Leave only on pc_load, which goes to FETCH.
- pc_load in FETCH with mem_req pending: go to DRAIN, latch pc_in. Wait for mem_ack, discard the byte, then FETCH at the new pc.
- pc_load in FETCH with no request pending: restart immediately.
- pc_load in DELIVER: the instruction is dropped (instr_valid falls next cycle) even if instr_ready is high the same cycle. Redirect wins.
- pc_load during DRAIN: overwrite the latched target.
- valP arithmetic is modulo 2^ADDR_W; pc+count is compared against MAX_ADDR before each byte.
- Reset mid-operation: immediate return to reset values; any outstanding memory ack afterwards is ignored.

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT=0, NOP=1, CMOVXX=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B)
  - RNONE=4'hF
  - fetch state enum
  - function instr_len(icode) returning length and a valid flag.
- Sub-module y86_instr_assembler: the 10-byte shift/collect buffer plus field extraction (rA/rB/valC muxing by icode). The FSM stays in the top level.

Test Plan:
1. pc_load pc_in=0, memory holds 0x10 then 0x00 -> NOP delivered (valP=1), then HALT delivered (valP=2); halted=1 after accept; no further mem_req.
2. irmovq at 1: bytes 30 F4 00 02 00.. -> icode=3, rA=F, rB=4, valC=0x200, valP=11; exactly 10 mem_req/ack pairs.
3. call at 57: 80 70 00.. with mem_ack delayed 3 cycles each -> valC=0x70, valP=66, rA=rB=F; mem_addr stable while waiting.
4. instr_ready held 0 for 5 cycles in DELIVER -> fields stable, no new mem_req; accept on cycle 6 -> next fetch at valP.
5. pc_load pc_in=2046 with 30 at 2046 -> byte 2047 fetched, then instr_error=1 with no request to 2048; state ERROR until pc_load pc_in=0.
6. pc_load pc_in=136 while mem_req pending mid-irmovq -> DRAIN consumes the ack, next mem_addr=136; icode 0xC at 136 -> instr_error=1, length 1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, register-none marker,
// fetch FSM state encodings and the instruction length decoder.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DELIVER = 3'd2;
    localparam logic [2:0] ST_HALTED  = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    typedef struct packed {
        logic [3:0] len;
        logic       valid;
    } len_info_t;

    // Unknown icodes still occupy one byte so valP stays meaningful.
    function automatic len_info_t instr_len(input logic [3:0] code);
        len_info_t r;
        r.len   = 4'd1;
        r.valid = 1'b1;
        case (code)
            I_HALT, I_NOP, I_RET:               r.len = 4'd1;
            I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:   r.len = 4'd2;
            I_JXX, I_CALL:                      r.len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       r.len = 4'd10;
            default:                            r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_instr_assembler.sv
// Collects up to ten instruction bytes by index and splits them into
// icode/ifun/rA/rB/valC according to the instruction format.
module y86_instr_assembler
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [7:0]  wr_data,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc
);

    logic [7:0] buffer [10];
    len_info_t  info;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) buffer[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 10; i++) buffer[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 10; i++) begin
                if (wr_idx == 4'(i)) buffer[i] <= wr_data;
            end
        end
    end

    assign icode = buffer[0][7:4];
    assign ifun  = buffer[0][3:0];
    assign info  = instr_len(buffer[0][7:4]);

    // The constant starts at byte 1 when there is no register byte, else at byte 2.
    always_comb begin
        ra   = RNONE;
        rb   = RNONE;
        valc = '0;
        if (info.valid) begin
            case (info.len)
                4'd2: begin
                    ra = buffer[1][7:4];
                    rb = buffer[1][3:0];
                end
                4'd9: begin
                    valc = {buffer[8], buffer[7], buffer[6], buffer[5],
                            buffer[4], buffer[3], buffer[2], buffer[1]};
                end
                4'd10: begin
                    ra   = buffer[1][7:4];
                    rb   = buffer[1][3:0];
                    valc = {buffer[9], buffer[8], buffer[7], buffer[6],
                            buffer[5], buffer[4], buffer[3], buffer[2]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/y86_fetch_sequencer.sv
// Byte-serial Y86-64 instruction fetch: walks the PC over a shared byte port,
// assembles each instruction and offers it to decode over valid/ready.
module y86_fetch_sequencer
    import y86_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(2047)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic              instr_error,
    output logic              halted
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc, drain_pc, fetch_addr, start_pc, valp_raw;
    logic [3:0]        count, cur_len;
    logic              range_err, addr_oob, take, start, deliver, raw_error;
    logic [3:0]        asm_icode, asm_ifun, asm_ra, asm_rb;
    logic [63:0]       asm_valc;
    len_info_t         len_now, len_buf;

    assign fetch_addr = pc + ADDR_W'(count);
    assign addr_oob   = fetch_addr > MAX_ADDR;
    assign mem_req    = (state == ST_FETCH && !addr_oob) || state == ST_DRAIN;
    assign mem_addr   = mem_req ? fetch_addr : '0;

    // Length is known from the incoming byte while byte 0 is being accepted.
    assign len_now   = instr_len(mem_rdata[7:4]);
    assign len_buf   = instr_len(asm_icode);
    assign cur_len   = (count == 4'd0) ? len_now.len : len_buf.len;
    assign take      = state == ST_FETCH && mem_req && mem_ack && !pc_load;
    assign valp_raw  = range_err ? pc : pc + ADDR_W'(len_buf.len);
    assign raw_error = range_err || !len_buf.valid;
    assign deliver   = state == ST_DELIVER;

    // Any event that begins a fresh instruction at start_pc; redirect beats accept.
    always_comb begin
        start    = 1'b0;
        start_pc = pc_in;
        case (state)
            ST_IDLE, ST_HALTED, ST_ERROR: start = pc_load;
            ST_FETCH: start = pc_load && !(mem_req && !mem_ack);
            ST_DELIVER: begin
                if (pc_load) begin
                    start = 1'b1;
                end else if (instr_ready && !raw_error && asm_icode != I_HALT) begin
                    start    = 1'b1;
                    start_pc = valp_raw;
                end
            end
            ST_DRAIN: begin
                start    = mem_ack;
                start_pc = pc_load ? pc_in : drain_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            drain_pc  <= '0;
            count     <= '0;
            range_err <= 1'b0;
        end else if (start) begin
            state     <= ST_FETCH;
            pc        <= start_pc;
            count     <= '0;
            range_err <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (pc_load) begin
                        drain_pc <= pc_in;
                        state    <= ST_DRAIN;
                    end else if (addr_oob) begin
                        range_err <= 1'b1;
                        state     <= ST_DELIVER;
                    end else if (mem_ack) begin
                        count <= count + 4'd1;
                        if (count + 4'd1 == cur_len) state <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (instr_ready) state <= raw_error ? ST_ERROR : ST_HALTED;
                end
                ST_DRAIN: begin
                    if (pc_load) drain_pc <= pc_in;
                end
                default: ;
            endcase
        end
    end

    y86_instr_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start),
        .wr_en   (take),
        .wr_idx  (count),
        .wr_data (mem_rdata),
        .icode   (asm_icode),
        .ifun    (asm_ifun),
        .ra      (asm_ra),
        .rb      (asm_rb),
        .valc    (asm_valc)
    );

    assign instr_valid = deliver;
    assign icode       = deliver ? asm_icode : 4'h0;
    assign ifun        = deliver ? asm_ifun  : 4'h0;
    assign rA          = deliver ? asm_ra    : RNONE;
    assign rB          = deliver ? asm_rb    : RNONE;
    assign valC        = deliver ? asm_valc  : '0;
    assign valP        = deliver ? valp_raw  : '0;
    assign instr_error = deliver && raw_error;
    assign halted      = state == ST_HALTED;

endmodule

// File: tb/tb_y86_fetch_sequencer.sv
// Directed bench for the fetch sequencer: a byte memory with programmable ack
// delay, a table of single-instruction fetches and hand-built redirect cases.
module tb_y86_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_load;
    logic [63:0] pc_in;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_error;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:2047];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          ack_count = 0;
    int          stab_err  = 0;
    int          oob_req   = 0;
    logic        pending   = 1'b0;
    logic [63:0] held_addr = '0;
    logic [63:0] ack_log[$];

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        int          delay;
        logic        chk_fields;
        logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
        logic [63:0] e_valc, e_valp;
        logic        e_err;
        int          e_reqs;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    y86_fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .instr_error (instr_error),
        .halted      (halted)
    );

    // Memory responder: acks after ack_delay waiting cycles and watches address stability.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && rst_n) begin
                if (mem_addr > 64'd2047) oob_req++;
                if (!pending) held_addr = mem_addr;
                else if (mem_addr != held_addr) stab_err++;
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[10:0]];
                    ack_log.push_back(mem_addr);
                    ack_count++;
                    pending  = 1'b0;
                    wait_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    pending = 1'b1;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                pending  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    function automatic vec_t mk(input logic [63:0] pc, input logic [79:0] bytes, input int delay,
                                input logic chk, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                                input logic [63:0] vp, input logic err, input int reqs);
        vec_t v;
        v.pc = pc; v.bytes = bytes; v.delay = delay; v.chk_fields = chk;
        v.e_icode = ic; v.e_ifun = fn; v.e_ra = ra; v.e_rb = rb;
        v.e_valc = vc; v.e_valp = vp; v.e_err = err; v.e_reqs = reqs;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [63:0] target);
        pc_in   = target;
        pc_load = 1'b1;
        ack_log.delete();
        ack_count = 0;
        stepCycle();
        pc_load = 1'b0;
    endtask

    task automatic waitValid(input int budget, output int cycles);
        cycles = 0;
        while (!instr_valid && cycles < budget) begin
            stepCycle();
            cycles++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("[TB] FAIL wait_valid: got timeout after %0d cycles, expected instr_valid", cycles);
        end
    endtask

    function automatic logic [63:0] logAt(input int idx);
        return (ack_log.size() > idx) ? ack_log[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    initial begin
        int   cyc;
        vec_t v;
        rst_n       = 1'b0;
        pc_load     = 1'b0;
        pc_in       = '0;
        instr_ready = 1'b0;

        vecs[0] = mk(64'd1,    80'h0000_0000_0000_0200_F430, 0, 1'b1, 4'h3, 4'h0, 4'hF, 4'h4, 64'h200, 64'd11, 1'b0, 10);
        vecs[1] = mk(64'd57,   80'h0000_0000_0000_0000_7080, 3, 1'b1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h70, 64'd66, 1'b0, 9);
        vecs[2] = mk(64'd100,  80'h0000_0000_0000_0000_2361, 0, 1'b1, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'd102, 1'b0, 2);
        vecs[3] = mk(64'd200,  80'h0102_0304_0506_0708_1540, 0, 1'b1, 4'h4, 4'h0, 4'h1, 4'h5,
                     64'h0102_0304_0506_0708, 64'd210, 1'b0, 10);
        vecs[4] = mk(64'd300,  80'h0000_0000_00DE_ADBE_EF74, 1, 1'b1, 4'h7, 4'h4, 4'hF, 4'hF, 64'hDEAD_BEEF, 64'd309, 1'b0, 9);
        vecs[5] = mk(64'd136,  80'h0000_0000_0000_0000_00C0, 0, 1'b1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd137, 1'b1, 1);
        vecs[6] = mk(64'd400,  80'h0000_0000_0000_0000_0090, 0, 1'b1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd401, 1'b0, 1);
        vecs[7] = mk(64'd500,  80'h0000_0000_0000_0000_4FA0, 2, 1'b1, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 64'd502, 1'b0, 2);
        vecs[8] = mk(64'd2046, 80'h0000_0000_0000_0000_F430, 0, 1'b0, 4'h3, 4'h0, 4'hF, 4'h4, 64'h0, 64'd2046, 1'b1, 2);
        vecs[9] = mk(64'd600,  80'h0000_0000_0000_0000_2FB0, 0, 1'b1, 4'hB, 4'h0, 4'h2, 4'hF, 64'h0, 64'd602, 1'b0, 2);

        for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            for (int k = 0; k < 10; k++) begin
                if (v.pc + 64'(k) <= 64'd2047) mem[v.pc + 64'(k)] = v.bytes[8*k +: 8];
            end
        end
        mem[1000] = 8'h10;
        mem[1001] = 8'h00;

        repeat (3) stepCycle();
        checkOutput("reset mem_req", mem_req, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset instr_valid", instr_valid, 0);
        checkOutput("reset icode", icode, 0);
        checkOutput("reset ifun", ifun, 0);
        checkOutput("reset rA", rA, 4'hF);
        checkOutput("reset rB", rB, 4'hF);
        checkOutput("reset valC", valC, 0);
        checkOutput("reset valP", valP, 0);
        checkOutput("reset instr_error", instr_error, 0);
        checkOutput("reset halted", halted, 0);
        rst_n = 1'b1;
        repeat (4) stepCycle();
        checkOutput("idle no request", ack_count, 0);
        checkOutput("idle mem_req", mem_req, 0);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            ack_delay = v.delay;
            applyStimulus(v.pc);
            waitValid(150, cyc);
            if (v.chk_fields) begin
                checkOutput($sformatf("row%0d icode", i), icode, v.e_icode);
                checkOutput($sformatf("row%0d ifun", i), ifun, v.e_ifun);
                checkOutput($sformatf("row%0d rA", i), rA, v.e_ra);
                checkOutput($sformatf("row%0d rB", i), rB, v.e_rb);
                checkOutput($sformatf("row%0d valC", i), valC, v.e_valc);
            end
            checkOutput($sformatf("row%0d valP", i), valP, v.e_valp);
            checkOutput($sformatf("row%0d instr_error", i), instr_error, v.e_err);
            checkOutput($sformatf("row%0d requests", i), ack_count, v.e_reqs);
            if (v.e_err) begin
                instr_ready = 1'b1;
                stepCycle();
                instr_ready = 1'b0;
                repeat (3) stepCycle();
                checkOutput($sformatf("row%0d error idle valid", i), instr_valid, 0);
                checkOutput($sformatf("row%0d error not halted", i), halted, 0);
                checkOutput($sformatf("row%0d error no fetch", i), ack_count, v.e_reqs);
            end
        end

        // NOP then HALT, with decode stalling on the NOP.
        ack_delay = 0;
        applyStimulus(64'd1000);
        waitValid(50, cyc);
        checkOutput("nop icode", icode, 4'h1);
        checkOutput("nop valP", valP, 64'd1001);
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput($sformatf("stall%0d valid", k), instr_valid, 1);
            checkOutput($sformatf("stall%0d valP", k), valP, 64'd1001);
            checkOutput($sformatf("stall%0d mem_req", k), mem_req, 0);
        end
        instr_ready = 1'b1;
        stepCycle();
        instr_ready = 1'b0;
        waitValid(50, cyc);
        checkOutput("halt icode", icode, 4'h0);
        checkOutput("halt valP", valP, 64'd1002);
        checkOutput("halt instr_error", instr_error, 0);
        checkOutput("halt fetched at valP", logAt(1), 64'd1001);
        instr_ready = 1'b1;
        stepCycle();
        instr_ready = 1'b0;
        checkOutput("halted flag", halted, 1);
        checkOutput("halted valid", instr_valid, 0);
        repeat (10) stepCycle();
        checkOutput("halted no fetch", ack_count, 2);
        checkOutput("halted stays", halted, 1);

        // Redirect in DELIVER wins over a same-cycle accept.
        applyStimulus(64'd100);
        waitValid(50, cyc);
        checkOutput("opq latency", cyc, 2);
        pc_in       = 64'd400;
        pc_load     = 1'b1;
        instr_ready = 1'b1;
        ack_log.delete();
        ack_count = 0;
        stepCycle();
        pc_load     = 1'b0;
        instr_ready = 1'b0;
        checkOutput("redirect drops valid", instr_valid, 0);
        waitValid(50, cyc);
        checkOutput("redirect icode", icode, 4'h9);
        checkOutput("redirect valP", valP, 64'd401);
        checkOutput("redirect first addr", logAt(0), 64'd400);

        // Redirect while a request is outstanding mid-irmovq.
        ack_delay = 3;
        applyStimulus(64'd1);
        cyc = 0;
        while (!(mem_ack && ack_count >= 3) && cyc < 100) begin
            stepCycle();
            cyc++;
        end
        checkOutput("drain setup acks", ack_count, 3);
        pc_in   = 64'd136;
        pc_load = 1'b1;
        ack_log.delete();
        ack_count = 0;
        stepCycle();
        pc_load = 1'b0;
        checkOutput("drain mem_req held", mem_req, 1);
        checkOutput("drain mem_addr held", mem_addr, 64'd4);
        waitValid(100, cyc);
        checkOutput("drain discarded addr", logAt(0), 64'd4);
        checkOutput("drain new addr", logAt(1), 64'd136);
        checkOutput("drain icode", icode, 4'hC);
        checkOutput("drain instr_error", instr_error, 1);
        checkOutput("drain valP", valP, 64'd137);
        checkOutput("drain requests", ack_count, 2);
        instr_ready = 1'b1;
        stepCycle();
        instr_ready = 1'b0;
        checkOutput("drain error state valid", instr_valid, 0);

        // Reset in the middle of a fetch.
        applyStimulus(64'd1);
        repeat (2) stepCycle();
        rst_n = 1'b0;
        #2;
        checkOutput("midreset mem_req", mem_req, 0);
        checkOutput("midreset valid", instr_valid, 0);
        checkOutput("midreset rA", rA, 4'hF);
        stepCycle();
        rst_n     = 1'b1;
        ack_count = 0;
        repeat (6) stepCycle();
        checkOutput("midreset no fetch", ack_count, 0);
        checkOutput("midreset halted", halted, 0);

        checkOutput("mem_addr stability", stab_err, 0);
        checkOutput("out of range request", oob_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
